// File: rtl/sram_1r1w_masked_array.sv
// Single-clock 1R1W SRAM array: per-segment write mask, 1/2-cycle read latency, zero-init sweep.
// Optional macro ARRAY_RW_BYPASS_EN: same-cycle same-address read is write-first (default read-first).
module sram_1r1w_masked_array #(
  parameter int DATA_WIDTH    = 320,
  parameter int DEPTH         = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int SEGMENTS      = 10,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  init_done,
  output logic                  w_ready,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [SEGMENTS-1:0]   w_mask,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_ready,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int SEG_W = DATA_WIDTH / SEGMENTS;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_sweepCnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_isReady;
  logic                  w_wrInRange;
  logic                  w_rdInRange;
  logic                  w_wrFire;
  logic                  w_rdFire;
  logic [DATA_WIDTH-1:0] w_rdWord;
  logic                  w_pipeValid;
  logic [DATA_WIDTH-1:0] w_pipeData;

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_INIT && r_sweepCnt == LAST_IDX) begin
      w_nextState = ST_READY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      r_sweepCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_INIT) begin
        r_sweepCnt <= r_sweepCnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Gating with reset keeps the handshakes low while reset is held, even when READY is entered during reset.
  assign w_isReady   = (r_state == ST_READY) && !reset;
  assign init_done   = w_isReady;
  assign w_ready     = w_isReady;
  assign r_ready     = w_isReady;

  assign w_wrInRange = {1'b0, w_addr} < DEPTH_EXT;
  assign w_rdInRange = {1'b0, r_addr} < DEPTH_EXT;
  assign w_wrFire    = w_en && w_isReady && w_wrInRange;
  assign w_rdFire    = r_en && w_isReady;

  always_ff @(posedge clock) begin
    if (!reset && r_state == ST_INIT) begin
      r_mem[r_sweepCnt] <= '0;
    end else if (w_wrFire) begin
      for (int i = 0; i < SEGMENTS; i++) begin
        if (w_mask[i]) begin
          r_mem[w_addr][i*SEG_W +: SEG_W] <= w_data[i*SEG_W +: SEG_W];
        end
      end
    end
  end

  // Out-of-range reads return zeros; the bypass merges only the enabled write segments.
  always_comb begin
    w_rdWord = '0;
    if (w_rdInRange) begin
      w_rdWord = r_mem[r_addr];
`ifdef ARRAY_RW_BYPASS_EN
      if (w_wrFire && (w_addr == r_addr)) begin
        for (int i = 0; i < SEGMENTS; i++) begin
          if (w_mask[i]) begin
            w_rdWord[i*SEG_W +: SEG_W] = w_data[i*SEG_W +: SEG_W];
          end
        end
      end
`endif
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_stgValid;
      logic [DATA_WIDTH-1:0] r_stgData;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_stgValid <= 1'b0;
          r_stgData  <= '0;
        end else begin
          r_stgValid <= w_rdFire;
          if (w_rdFire) begin
            r_stgData <= w_rdWord;
          end
        end
      end

      assign w_pipeValid = r_stgValid;
      assign w_pipeData  = r_stgData;
    end else begin : g_lat1
      assign w_pipeValid = w_rdFire;
      assign w_pipeData  = w_rdWord;
    end
  endgenerate

  // Output stage: r_data only moves with r_valid so it holds the last result while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_pipeValid;
      if (w_pipeValid) begin
        r_data <= w_pipeData;
      end
    end
  end

endmodule

// File: tb/tb_sram_1r1w_masked_array.sv
// Directed bench for sram_1r1w_masked_array: instance A (DEPTH 64, latency 1), instance B (DEPTH 48, latency 2).
module tb_sram_1r1w_masked_array;

  localparam int DW = 320;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO = '0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          aWEn, aREn, aInitDone, aWReady, aRReady, aRValid;
  logic [5:0]    aWAddr, aRAddr;
  logic [9:0]    aWMask;
  logic [DW-1:0] aWData, aRData;

  logic          bWEn, bREn, bInitDone, bWReady, bRReady, bRValid;
  logic [5:0]    bWAddr, bRAddr;
  logic [9:0]    bWMask;
  logic [DW-1:0] bWData, bRData;

  int checks = 0;
  int failures = 0;

  sram_1r1w_masked_array dutA (
    .clock(clock), .reset(reset), .init_done(aInitDone),
    .w_ready(aWReady), .w_en(aWEn), .w_addr(aWAddr), .w_mask(aWMask), .w_data(aWData),
    .r_ready(aRReady), .r_en(aREn), .r_addr(aRAddr), .r_valid(aRValid), .r_data(aRData)
  );

  sram_1r1w_masked_array #(.DEPTH(48), .READ_LATENCY(2)) dutB (
    .clock(clock), .reset(reset), .init_done(bInitDone),
    .w_ready(bWReady), .w_en(bWEn), .w_addr(bWAddr), .w_mask(bWMask), .w_data(bWData),
    .r_ready(bRReady), .r_en(bREn), .r_addr(bRAddr), .r_valid(bRValid), .r_data(bRData)
  );

  task aWrite(input logic [5:0] addr, input logic [9:0] mask, input logic [DW-1:0] data);
    aWEn = 1'b1; aWAddr = addr; aWMask = mask; aWData = data;
    @(negedge clock);
    aWEn = 1'b0;
  endtask

  task bWrite(input logic [5:0] addr, input logic [9:0] mask, input logic [DW-1:0] data);
    bWEn = 1'b1; bWAddr = addr; bWMask = mask; bWData = data;
    @(negedge clock);
    bWEn = 1'b0;
  endtask

  task aRead(input logic [5:0] addr);
    aREn = 1'b1; aRAddr = addr;
    @(negedge clock);
    aREn = 1'b0;
  endtask

  task bRead(input logic [5:0] addr);
    bREn = 1'b1; bRAddr = addr;
    @(negedge clock);
    bREn = 1'b0;
  endtask

  task waitInitDone(output int aCyc, output int bCyc);
    aCyc = -1;
    bCyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (aInitDone && aCyc < 0) aCyc = c;
      if (bInitDone && bCyc < 0) bCyc = c;
      if (aCyc >= 0 && bCyc >= 0) break;
    end
  endtask

  task test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({aInitDone, aWReady, aRReady, aRValid} !== 4'b0000) begin
      $display("[TB] FAIL reset_a_flags: got %b expected 0000", {aInitDone, aWReady, aRReady, aRValid});
      failures++;
    end
    checks++;
    if ({bInitDone, bWReady, bRReady, bRValid} !== 4'b0000) begin
      $display("[TB] FAIL reset_b_flags: got %b expected 0000", {bInitDone, bWReady, bRReady, bRValid});
      failures++;
    end
    checks++;
    if (aRData !== ZERO || bRData !== ZERO) begin
      $display("[TB] FAIL reset_rdata: got a=%h b=%h expected 0", aRData, bRData);
      failures++;
    end
  endtask

  task test_init;
    int aCyc, bCyc;
    int addrs[3] = '{0, 37, 63};
    reset = 1'b0;
    waitInitDone(aCyc, bCyc);
    checks++;
    if (aCyc != 64) begin
      $display("[TB] FAIL init_cycles_a: got %0d expected 64", aCyc);
      failures++;
    end
    checks++;
    if (bCyc != 48) begin
      $display("[TB] FAIL init_cycles_b: got %0d expected 48", bCyc);
      failures++;
    end
    foreach (addrs[i]) begin
      aRead(6'(addrs[i]));
      checks++;
      if ({aRValid, aRData} !== {1'b1, ZERO}) begin
        $display("[TB] FAIL init_read_%0d: got valid=%b data=%h expected valid=1 data=0", addrs[i], aRValid, aRData);
        failures++;
      end
    end
  endtask

  task test_mask;
    logic [DW-1:0] expLow, expTop;
    expLow = {{(DW-32){1'b1}}, 32'h0};
    expTop = {32'hFFFF_FFFF, {(DW-32){1'b0}}};
    aWrite(6'd5, 10'h3FF, ONES);
    aWrite(6'd5, 10'h001, ZERO);
    aRead(6'd5);
    checks++;
    if ({aRValid, aRData} !== {1'b1, expLow}) begin
      $display("[TB] FAIL mask_low: got valid=%b data=%h expected valid=1 data=%h", aRValid, aRData, expLow);
      failures++;
    end
    @(negedge clock);
    checks++;
    if ({aRValid, aRData} !== {1'b0, expLow}) begin
      $display("[TB] FAIL mask_hold: got valid=%b data=%h expected valid=0 data=%h", aRValid, aRData, expLow);
      failures++;
    end
    aWrite(6'd5, 10'h000, ZERO);
    aRead(6'd5);
    checks++;
    if (aRData !== expLow) begin
      $display("[TB] FAIL mask_zero_noop: got %h expected %h", aRData, expLow);
      failures++;
    end
    aWrite(6'd7, 10'h200, ONES);
    aRead(6'd7);
    checks++;
    if ({aRValid, aRData} !== {1'b1, expTop}) begin
      $display("[TB] FAIL mask_top: got valid=%b data=%h expected valid=1 data=%h", aRValid, aRData, expTop);
      failures++;
    end
  endtask

  task test_collision;
    logic [DW-1:0] expFull, expPart;
`ifdef ARRAY_RW_BYPASS_EN
    expFull = ONES;
    expPart = {{(DW-32){1'b0}}, 32'hFFFF_FFFF};
`else
    expFull = ZERO;
    expPart = ZERO;
`endif
    aWEn = 1'b1; aWAddr = 6'd9; aWMask = 10'h3FF; aWData = ONES;
    aREn = 1'b1; aRAddr = 6'd9;
    @(negedge clock);
    aWEn = 1'b0; aREn = 1'b0;
    checks++;
    if ({aRValid, aRData} !== {1'b1, expFull}) begin
      $display("[TB] FAIL collide_full: got valid=%b data=%h expected valid=1 data=%h", aRValid, aRData, expFull);
      failures++;
    end
    aRead(6'd9);
    checks++;
    if (aRData !== ONES) begin
      $display("[TB] FAIL collide_after: got %h expected %h", aRData, ONES);
      failures++;
    end
    aWEn = 1'b1; aWAddr = 6'd10; aWMask = 10'h001; aWData = ONES;
    aREn = 1'b1; aRAddr = 6'd10;
    @(negedge clock);
    aWEn = 1'b0; aREn = 1'b0;
    checks++;
    if (aRData !== expPart) begin
      $display("[TB] FAIL collide_partial: got %h expected %h", aRData, expPart);
      failures++;
    end
    aWEn = 1'b1; aWAddr = 6'd11; aWMask = 10'h3FF; aWData = ONES;
    aREn = 1'b1; aRAddr = 6'd12;
    @(negedge clock);
    aWEn = 1'b0; aREn = 1'b0;
    checks++;
    if (aRData !== ZERO) begin
      $display("[TB] FAIL independent_read: got %h expected 0", aRData);
      failures++;
    end
    aRead(6'd11);
    checks++;
    if (aRData !== ONES) begin
      $display("[TB] FAIL independent_write: got %h expected %h", aRData, ONES);
      failures++;
    end
  endtask

  task test_back_to_back;
    int expIdx;
    for (int i = 0; i < 16; i++) bWrite(6'(i), 10'h3FF, DW'(i));
    expIdx = 0;
    for (int c = 0; c < 20; c++) begin
      bREn = (c < 16);
      bRAddr = 6'(c);
      @(negedge clock);
      if (bRValid) begin
        checks++;
        if (bRData !== DW'(expIdx) || c != expIdx + 1) begin
          $display("[TB] FAIL b2b_pulse: got data=%0h at cycle %0d expected data=%0h at cycle %0d", bRData, c, expIdx, expIdx + 1);
          failures++;
        end
        expIdx++;
      end
    end
    bREn = 1'b0;
    checks++;
    if (expIdx != 16) begin
      $display("[TB] FAIL b2b_count: got %0d pulses expected 16", expIdx);
      failures++;
    end
    checks++;
    if ({bRValid, bRData} !== {1'b0, DW'(15)}) begin
      $display("[TB] FAIL b2b_hold: got valid=%b data=%0h expected valid=0 data=f", bRValid, bRData);
      failures++;
    end
    bRead(6'd3);
    bWrite(6'd3, 10'h3FF, ONES);
    checks++;
    if ({bRValid, bRData} !== {1'b1, DW'(3)}) begin
      $display("[TB] FAIL read_before_write: got valid=%b data=%h expected valid=1 data=3", bRValid, bRData);
      failures++;
    end
  endtask

  task test_bounds;
    logic [DW-1:0] exp [48];
    int idx;
    bWrite(6'd50, 10'h3FF, ONES);
    bRead(6'd50);
    @(negedge clock);
    checks++;
    if ({bRValid, bRData} !== {1'b1, ZERO}) begin
      $display("[TB] FAIL bounds_read: got valid=%b data=%h expected valid=1 data=0", bRValid, bRData);
      failures++;
    end
    for (int i = 0; i < 48; i++) begin
      if (i < 16) exp[i] = DW'(i);
      else exp[i] = ZERO;
    end
    exp[3] = ONES;
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      bREn = (c < 48);
      bRAddr = 6'(c);
      @(negedge clock);
      if (bRValid) begin
        checks++;
        if (idx >= 48 || bRData !== exp[idx]) begin
          $display("[TB] FAIL bounds_entry_%0d: got %h expected %h", idx, bRData, (idx < 48) ? exp[idx] : ZERO);
          failures++;
        end
        idx++;
      end
    end
    bREn = 1'b0;
    checks++;
    if (idx != 48) begin
      $display("[TB] FAIL bounds_count: got %0d reads expected 48", idx);
      failures++;
    end
  endtask

  task test_reset_mid_init;
    int aCyc, bCyc;
    logic sawValid;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if ({aInitDone, bInitDone} !== 2'b00) begin
      $display("[TB] FAIL mid_init_flags: got %b expected 00", {aInitDone, bInitDone});
      failures++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    waitInitDone(aCyc, bCyc);
    checks++;
    if (aCyc != 64 || bCyc != 48) begin
      $display("[TB] FAIL mid_init_cycles: got a=%0d b=%0d expected a=64 b=48", aCyc, bCyc);
      failures++;
    end
    bWrite(6'd1, 10'h3FF, ONES);
    bRead(6'd1);
    @(negedge clock);
    checks++;
    if ({bRValid, bRData} !== {1'b1, ONES}) begin
      $display("[TB] FAIL pre_reset_read: got valid=%b data=%h expected valid=1 data=%h", bRValid, bRData, ONES);
      failures++;
    end
    bRead(6'd1);
    reset = 1'b1;
    sawValid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bRValid) sawValid = 1'b1;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (bRValid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin
      $display("[TB] FAIL dropped_read_valid: got %b expected 0", sawValid);
      failures++;
    end
    checks++;
    if (bRData !== ZERO || aRData !== ZERO) begin
      $display("[TB] FAIL dropped_read_data: got a=%h b=%h expected 0", aRData, bRData);
      failures++;
    end
  endtask

  initial begin
    reset = 1'b1;
    aWEn = 1'b0; aREn = 1'b0; aWAddr = '0; aRAddr = '0; aWMask = '0; aWData = '0;
    bWEn = 1'b0; bREn = 1'b0; bWAddr = '0; bRAddr = '0; bWMask = '0; bWData = '0;
    @(negedge clock);
    test_reset;
    test_init;
    test_mask;
    test_collision;
    test_back_to_back;
    test_bounds;
    test_reset_mid_init;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
